// File: rtl/access_arbiter_if.sv
// Bus-side bundle between the requesters and access_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface access_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 3,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ID_W-1:0]   usr_id;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        nack;
  logic [DATA_W-1:0]       data_out;
  logic [7:0]              deny_cnt;
  logic                    locked;

  modport master (
    output req, usr_id, wdata,
    input  gnt, ack, nack, data_out, deny_cnt, locked
  );

  modport slave (
    input  req, usr_id, wdata,
    output gnt, ack, nack, data_out, deny_cnt, locked
  );
endinterface

// File: rtl/access_arbiter.sv
// Round-robin arbiter guarding a privileged data register: authorized IDs write it,
// denials are counted (saturating) and a sticky lockout latches at LOCK_THRESH.
module access_arbiter #(
  parameter int               N_REQ       = 4,
  parameter int               ID_W        = 3,
  parameter int               DATA_W      = 8,
  parameter logic [2**ID_W-1:0] AUTH_MASK = 8'h10,
  parameter logic [7:0]       LOCK_THRESH = 8'd15
) (
  input  logic            clk,
  input  logic            rst_n,
  access_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic [ID_W-1:0]     r_lat_id;
  logic [DATA_W-1:0]   r_lat_data;
  logic [N_REQ-1:0]    r_gnt;
  logic [N_REQ-1:0]    r_ack;
  logic [N_REQ-1:0]    r_nack;
  logic [DATA_W-1:0]   r_data;
  logic [7:0]          r_deny;
  logic                r_locked;

  logic [IDX_W:0]      w_pick;
  logic                w_pick_vld;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [ID_W-1:0]     w_sel_id;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_auth;
  logic [7:0]          w_deny_inc;
  logic [IDX_W-1:0]    w_rr_next;

  // Scan from ptr downward in priority order; the last hit (smallest offset) wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int             j;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j   = int'(ptr) + k;
      j   = (j >= N_REQ) ? j - N_REQ : j;
      res = req_v[j] ? {1'b1, IDX_W'(j)} : res;
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_pick     = rr_pick(bus.req, r_rr_ptr);
  assign w_pick_vld = w_pick[IDX_W];
  assign w_pick_idx = w_pick[IDX_W-1:0];
  assign w_sel_id   = bus.usr_id[int'(w_pick_idx)*ID_W +: ID_W];
  assign w_sel_data = bus.wdata[int'(w_pick_idx)*DATA_W +: DATA_W];
  assign w_auth     = AUTH_MASK[r_lat_id] & ~r_locked;
  assign w_deny_inc = (r_deny == 8'd255) ? 8'd255 : r_deny + 8'd1;
  assign w_rr_next  = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);

  // Next-state logic: IDLE -> GRANT -> RESP -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) w_next_state = S_GRANT;
        else            w_next_state = S_IDLE;
      end
      S_GRANT: w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Datapath: latch winner, commit or deny, update counters and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_idx      <= '0;
      r_lat_id   <= '0;
      r_lat_data <= '0;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_nack     <= '0;
      r_data     <= '0;
      r_deny     <= 8'd0;
      r_locked   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack  <= '0;
          r_nack <= '0;
          if (w_pick_vld) begin
            r_idx      <= w_pick_idx;
            r_lat_id   <= w_sel_id;
            r_lat_data <= w_sel_data;
            r_gnt      <= onehot(w_pick_idx);
          end else begin
            r_gnt <= '0;
          end
        end
        S_GRANT: begin
          r_gnt    <= '0;
          r_rr_ptr <= w_rr_next;
          if (w_auth) begin
            r_data <= r_lat_data;
            r_ack  <= onehot(r_idx);
          end else begin
            r_nack <= onehot(r_idx);
            r_deny <= w_deny_inc;
            if (w_deny_inc >= LOCK_THRESH) r_locked <= 1'b1;
          end
        end
        S_RESP: begin
          r_ack  <= '0;
          r_nack <= '0;
        end
        default: begin
          r_gnt  <= '0;
          r_ack  <= '0;
          r_nack <= '0;
        end
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.ack      = r_ack;
  assign bus.nack     = r_nack;
  assign bus.data_out = r_data;
  assign bus.deny_cnt = r_deny;
  assign bus.locked   = r_locked;
endmodule

// File: tb/tb_access_arbiter.sv
// Directed bench for access_arbiter: main instance with default thresholds plus a
// second instance with LOCK_THRESH=255 for the saturation case.
module tb_access_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  access_arbiter_if #(.N_REQ(4), .ID_W(3), .DATA_W(8)) bif ();
  access_arbiter_if #(.N_REQ(4), .ID_W(3), .DATA_W(8)) sif ();

  access_arbiter #(
    .N_REQ(4), .ID_W(3), .DATA_W(8), .AUTH_MASK(8'h10), .LOCK_THRESH(8'd15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave)
  );

  access_arbiter #(
    .N_REQ(4), .ID_W(3), .DATA_W(8), .AUTH_MASK(8'h10), .LOCK_THRESH(8'd255)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] id, input logic [7:0] d);
    bif.req[i]            = 1'b1;
    bif.usr_id[i*3 +: 3]  = id;
    bif.wdata[i*8 +: 8]   = d;
  endtask

  // One single-requester transaction; called right after a falling edge in IDLE.
  task automatic txn(input string tag, input int i, input logic [2:0] id, input logic [7:0] d,
                     input bit ok, input logic [7:0] exp_data, input logic [7:0] exp_cnt,
                     input bit exp_lock);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    set_req(i, id, d);
    @(negedge clk);
    check({tag, ".gnt"}, 32'(bif.gnt), 32'(oh));
    bif.req = 4'b0000;
    @(negedge clk);
    check({tag, ".ack"},  32'(bif.ack),  32'(ok ? oh : 4'b0000));
    check({tag, ".nack"}, 32'(bif.nack), 32'(ok ? 4'b0000 : oh));
    check({tag, ".data"}, 32'(bif.data_out), 32'(exp_data));
    check({tag, ".cnt"},  32'(bif.deny_cnt), 32'(exp_cnt));
    check({tag, ".lock"}, 32'(bif.locked),   32'(exp_lock));
    @(negedge clk);
    check({tag, ".idle"}, 32'({bif.gnt, bif.ack, bif.nack}), 32'(12'h000));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rr_data [4];
    logic [3:0] oh;
    rr_data = '{8'h11, 8'h22, 8'h33, 8'h44};

    bif.req = '0; bif.usr_id = '0; bif.wdata = '0;
    sif.req = '0; sif.usr_id = '0; sif.wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.gnt",  32'(bif.gnt),      32'd0);
    check("rst.ack",  32'(bif.ack),      32'd0);
    check("rst.nack", 32'(bif.nack),     32'd0);
    check("rst.data", 32'(bif.data_out), 32'd0);
    check("rst.cnt",  32'(bif.deny_cnt), 32'd0);
    check("rst.lock", 32'(bif.locked),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle0.gnt", 32'(bif.gnt), 32'd0);

    txn("auth", 0, 3'd4, 8'hA5, 1'b1, 8'hA5, 8'd0, 1'b0);
    txn("deny", 1, 3'd3, 8'h5A, 1'b0, 8'hA5, 8'd1, 1'b0);

    // ID and data change after latching must not affect the transaction
    set_req(1, 3'd3, 8'h66);
    @(negedge clk);
    check("idchg.gnt", 32'(bif.gnt), 32'(4'b0010));
    bif.usr_id[5:3] = 3'd4;
    bif.wdata[15:8] = 8'h77;
    bif.req = 4'b0000;
    @(negedge clk);
    check("idchg.nack", 32'(bif.nack),     32'(4'b0010));
    check("idchg.ack",  32'(bif.ack),      32'd0);
    check("idchg.data", 32'(bif.data_out), 32'(8'hA5));
    check("idchg.cnt",  32'(bif.deny_cnt), 32'd2);
    @(negedge clk);

    // Asynchronous reset during GRANT
    set_req(2, 3'd4, 8'h99);
    @(negedge clk);
    check("mrst.gnt_pre", 32'(bif.gnt), 32'(4'b0100));
    bif.req = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    check("mrst.gnt",  32'(bif.gnt),      32'd0);
    check("mrst.data", 32'(bif.data_out), 32'd0);
    check("mrst.cnt",  32'(bif.deny_cnt), 32'd0);
    check("mrst.lock", 32'(bif.locked),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst.idle", 32'({bif.gnt, bif.ack, bif.nack}), 32'd0);
    end

    // Round-robin with all requests held
    bif.usr_id = {3'd4, 3'd4, 3'd4, 3'd4};
    bif.wdata  = {8'h44, 8'h33, 8'h22, 8'h11};
    bif.req    = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      @(negedge clk);
      check("rr.gnt", 32'(bif.gnt), 32'(oh));
      @(negedge clk);
      check("rr.ack",  32'(bif.ack),      32'(oh));
      check("rr.data", 32'(bif.data_out), 32'(rr_data[k % 4]));
      @(negedge clk);
      check("rr.idle", 32'({bif.gnt, bif.ack, bif.nack}), 32'd0);
    end
    bif.req = 4'b0000;

    // Lockout after 15 denials, then an authorized ID is still refused
    for (int k = 0; k < 15; k++)
      txn("lock", k % 4, 3'd3, 8'hF0, 1'b0, 8'h11, 8'(k + 1), (k + 1) >= 15);
    txn("locked", 0, 3'd4, 8'h3C, 1'b0, 8'h11, 8'd16, 1'b1);

    // Saturation on the LOCK_THRESH=255 instance
    for (int k = 1; k <= 260; k++) begin
      sif.req = 4'b0001;
      @(negedge clk);
      sif.req = 4'b0000;
      @(negedge clk);
      if (k == 254) begin
        check("sat.cnt254",  32'(sif.deny_cnt), 32'd254);
        check("sat.lock254", 32'(sif.locked),   32'd0);
      end
      if (k == 255) begin
        check("sat.cnt255",  32'(sif.deny_cnt), 32'd255);
        check("sat.lock255", 32'(sif.locked),   32'd1);
      end
      if (k == 260) begin
        check("sat.cnt260",  32'(sif.deny_cnt), 32'd255);
        check("sat.lock260", 32'(sif.locked),   32'd1);
        check("sat.nack",    32'(sif.nack),     32'(4'b0001));
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
